// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline defaults, stage indices and saturating-add helper
package pipe_pkg;
  localparam int STAGES_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB = 4;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? CNT_MAX : s[31:0];
  endfunction
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one pipeline register with valid, hold, bubble and flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              bubble_o
);
  logic [DATA_W-1:0] q_d, q_q;
  logic              valid_d, valid_q;
  always_comb begin
    bubble_o = bubble & ~hold & ~flush;
    q_d = (flush | bubble_o) ? '0 : hold ? q_q : d;
    valid_d = (flush | bubble_o) ? 1'b0 : hold ? valid_q : d_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q <= q_d;
      valid_q <= valid_d;
    end
  end
  assign q = q_q;
  assign q_valid = valid_q;
endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: STAGES pipeline registers with stall resolution; perf counters under PIPE_PERF_EN
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STAGES:0]          stall_req_i,
  input  logic [STAGES-1:0]        flush_i,
  input  logic [STAGES*DATA_W-1:0] d_i,
  input  logic [STAGES-1:0]        d_valid_i,
  output logic [STAGES*DATA_W-1:0] q_o,
  output logic [STAGES-1:0]        q_valid_o,
  output logic [STAGES:0]          stall_o,
  output logic [31:0]              stall_cycles_o,
  output logic [31:0]              bubble_cnt_o
);
  logic [STAGES-1:0] bubble;
  always_comb begin
    stall_o = '0;
    for (int s = 0; s <= STAGES; s++) stall_o[s] = |(stall_req_i >> s);
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_reg
    pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
      .clk      (clk),
      .rst      (rst),
      .hold     (stall_o[k+1]),
      .bubble   (stall_o[k]),
      .flush    (flush_i[k]),
      .d        (d_i[k*DATA_W +: DATA_W]),
      .d_valid  (d_valid_i[k]),
      .q        (q_o[k*DATA_W +: DATA_W]),
      .q_valid  (q_valid_o[k]),
      .bubble_o (bubble[k])
    );
  end
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_d, stall_cycles_q, bubble_cnt_d, bubble_cnt_q, bubble_n;
  always_comb begin
    bubble_n = '0;
    for (int k = 0; k < STAGES; k++) bubble_n = bubble_n + {31'b0, bubble[k]};
    stall_cycles_d = sat_add(stall_cycles_q, {31'b0, |stall_o});
    bubble_cnt_d = sat_add(bubble_cnt_q, bubble_n);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= ZERO_WORD;
      bubble_cnt_q <= ZERO_WORD;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end
  assign stall_cycles_o = stall_cycles_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_bubble;
  assign unused_bubble = ^bubble;
  assign stall_cycles_o = ZERO_WORD;
  assign bubble_cnt_o = ZERO_WORD;
`endif
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed checks of hold, bubble, flush, reset and counters
module tb_pipe_chain;
  localparam int S = 4;
  localparam int W = 32;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic           clk, rst;
  logic [S:0]     stall_req_i, stall_o;
  logic [S-1:0]   flush_i, d_valid_i, q_valid_o;
  logic [S*W-1:0] d_i, q_o;
  logic [31:0]    stall_cycles_o, bubble_cnt_o;
  int checks = 0;
  int errors = 0;
  pipe_chain #(.STAGES(S), .DATA_W(W)) dut (
    .clk(clk), .rst(rst), .stall_req_i(stall_req_i), .flush_i(flush_i),
    .d_i(d_i), .d_valid_i(d_valid_i), .q_o(q_o), .q_valid_o(q_valid_o),
    .stall_o(stall_o), .stall_cycles_o(stall_cycles_o), .bubble_cnt_o(bubble_cnt_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [31:0] ce(input logic [31:0] v);
    return PERF ? v : 32'h0;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic loop(input logic [31:0] tag, input logic v);
    d_i = {q_o[(S-1)*W-1:0], tag};
    d_valid_i = {q_valid_o[S-2:0], v};
    tick();
  endtask
  initial begin
    rst = 1'b1;
    stall_req_i = '0;
    flush_i = '0;
    d_i = {S*W{1'b1}};
    d_valid_i = '1;
    tick();
    tick();
    chk("rst_q", q_o, 0);
    chk("rst_valid", q_valid_o, 0);
    chk("rst_stall_cyc", stall_cycles_o, 0);
    chk("rst_bubble", bubble_cnt_o, 0);
    stall_req_i = 5'b00100;
    #1;
    chk("rst_stall_comb", stall_o, 5'b00111);
    stall_req_i = '0;
    rst = 1'b0;
    tick();
    chk("first_load_q", q_o, {S*W{1'b1}});
    chk("first_load_valid", q_valid_o, 4'hF);
    flush_i = 4'hF;
    tick();
    flush_i = '0;
    chk("flush_all_q", q_o, 0);
    chk("flush_all_valid", q_valid_o, 0);
    loop(32'h1, 1'b1);
    loop(32'h2, 1'b1);
    loop(32'h3, 1'b1);
    chk("flow_mid_q", q_o, {32'h0, 32'h1, 32'h2, 32'h3});
    loop(32'h4, 1'b1);
    chk("flow_tag_s3", q_o[3*W +: W], 32'h1);
    chk("flow_q", q_o, {32'h1, 32'h2, 32'h3, 32'h4});
    chk("flow_valid", q_valid_o, 4'hF);
    chk("flow_bubble", bubble_cnt_o, 0);
    stall_req_i = 5'b00100;
    #1;
    chk("ex_stall_o", stall_o, 5'b00111);
    loop(32'h5, 1'b1);
    chk("ex1_q", q_o, {32'h2, 32'h0, 32'h3, 32'h4});
    chk("ex1_valid", q_valid_o, 4'b1011);
    chk("ex1_bubble", bubble_cnt_o, ce(1));
    loop(32'h5, 1'b1);
    loop(32'h5, 1'b1);
    chk("ex3_q", q_o, {32'h0, 32'h0, 32'h3, 32'h4});
    chk("ex3_valid2", q_valid_o[2], 1'b0);
    chk("ex3_bubble", bubble_cnt_o, ce(3));
    chk("ex3_stall_cyc", stall_cycles_o, ce(3));
    stall_req_i = '0;
    loop(32'h5, 1'b1);
    chk("resume_q", q_o, {32'h0, 32'h3, 32'h4, 32'h5});
    chk("resume_valid", q_valid_o, 4'b0111);
    stall_req_i = 5'b00010;
    flush_i = 4'b0011;
    loop(32'h6, 1'b1);
    flush_i = '0;
    chk("flush_stall_q", q_o, {32'h3, 32'h4, 32'h0, 32'h0});
    chk("flush_stall_valid", q_valid_o, 4'b1100);
    chk("flush_stall_bubble", bubble_cnt_o, ce(3));
    chk("flush_stall_cyc", stall_cycles_o, ce(4));
    stall_req_i = 5'b10000;
    #1;
    chk("wb_stall_o", stall_o, 5'b11111);
    loop(32'h7, 1'b1);
    loop(32'h7, 1'b1);
    chk("wb_q", q_o, {32'h3, 32'h4, 32'h0, 32'h0});
    chk("wb_valid", q_valid_o, 4'b1100);
    chk("wb_bubble", bubble_cnt_o, ce(3));
    chk("wb_stall_cyc", stall_cycles_o, ce(6));
    stall_req_i = 5'b00001;
    #1;
    chk("if_stall_o", stall_o, 5'b00001);
    loop(32'h7, 1'b1);
    chk("if_bubble_q", q_o, {32'h4, 32'h0, 32'h0, 32'h0});
    chk("if_bubble_valid", q_valid_o, 4'b1000);
    chk("if_bubble_cnt", bubble_cnt_o, ce(4));
    chk("if_stall_cyc", stall_cycles_o, ce(7));
    stall_req_i = '0;
`ifdef PIPE_PERF_EN
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    chk("sat_preset", stall_cycles_o, 32'hFFFF_FFFE);
`endif
    stall_req_i = 5'b00100;
    loop(32'h8, 1'b1);
    chk("sat1", stall_cycles_o, ce(32'hFFFF_FFFF));
    loop(32'h8, 1'b1);
    loop(32'h8, 1'b1);
    chk("sat3", stall_cycles_o, ce(32'hFFFF_FFFF));
    chk("sat_bubble", bubble_cnt_o, ce(7));
    rst = 1'b1;
    d_i = {S*W{1'b1}};
    d_valid_i = '1;
    tick();
    chk("rst_mid_q", q_o, 0);
    chk("rst_mid_valid", q_valid_o, 0);
    chk("rst_mid_stall_cyc", stall_cycles_o, 0);
    chk("rst_mid_bubble", bubble_cnt_o, 0);
    rst = 1'b0;
    stall_req_i = '0;
    tick();
    chk("post_rst_q", q_o, {S*W{1'b1}});
    chk("post_rst_valid", q_valid_o, 4'hF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
